// File: rtl/mem_pkg.sv
// Shared types and encodings for the data-memory request path.
// Holds the store/load op encodings and the queued request record.
package mem_pkg;

  // Store op encodings (one-hot size).
  localparam logic [2:0] ST_NONE = 3'b000;
  localparam logic [2:0] ST_SB   = 3'b001;
  localparam logic [2:0] ST_SH   = 3'b010;
  localparam logic [2:0] ST_SW   = 3'b100;

  // Load op encodings.
  localparam logic [2:0] LD_NONE = 3'b000;
  localparam logic [2:0] LD_LBU  = 3'b001;
  localparam logic [2:0] LD_LHU  = 3'b010;
  localparam logic [2:0] LD_LB   = 3'b011;
  localparam logic [2:0] LD_LH   = 3'b100;
  localparam logic [2:0] LD_LW   = 3'b101;

  // Destination tag width carried in each queue entry. The arbiter's TAG_W
  // parameter must be kept equal to this.
  localparam int MEM_TAG_W = 5;

  typedef struct packed {
    logic [2:0]           wr;
    logic [2:0]           rd;
    logic [31:0]          addr;
    logic [31:0]          wdata;
    logic [MEM_TAG_W-1:0] tag;
  } mem_req_t;

  // A lane carries work only if it names a load or a store.
  function automatic logic has_op(input logic [2:0] wr, input logic [2:0] rd);
    return (wr != ST_NONE) || (rd != LD_NONE);
  endfunction

  // Build a queue entry; a lane naming both a store and a load is a store.
  function automatic mem_req_t make_req(input logic [2:0]           wr,
                                        input logic [2:0]           rd,
                                        input logic [31:0]          addr,
                                        input logic [31:0]          wdata,
                                        input logic [MEM_TAG_W-1:0] tag);
    mem_req_t r;
    r.wr    = wr;
    r.rd    = (wr != ST_NONE) ? LD_NONE : rd;
    r.addr  = addr;
    r.wdata = wdata;
    r.tag   = tag;
    return r;
  endfunction

endpackage

// File: rtl/mem_req_fifo.sv
// Circular request queue: up to two writes and one read per cycle.
// Head entry is visible combinationally so it can issue the cycle it is popped.
// wr1_en is only ever asserted together with wr0_en (wr1 lands behind wr0).
module mem_req_fifo
  import mem_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr0_en,
  input  mem_req_t      wr0_data,
  input  logic          wr1_en,
  input  mem_req_t      wr1_data,
  input  logic          rd_en,
  output mem_req_t      rd_data,
  output logic [CW-1:0] count
);

  mem_req_t      entries [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [1:0]    enq_cnt;

  assign enq_cnt = (wr0_en && wr1_en) ? 2'd2 : (wr0_en ? 2'd1 : 2'd0);
  assign rd_data = entries[rd_ptr];

  // Entry storage: no reset needed, validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (wr0_en) entries[wr_ptr] <= wr0_data;
    if (wr1_en) entries[wr_ptr + PW'(1)] <= wr1_data;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally mod DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(enq_cnt);
      rd_ptr <= rd_ptr + PW'(rd_en);
      count  <= count + CW'(enq_cnt) - CW'(rd_en);
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Two-lane load/store arbiter in front of data-memory port 0.
// Lanes are queued in program order (lane 0 older) and issued one per cycle;
// load results come back one cycle after issue, tagged with the destination.
module mem_req_arbiter
  import mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = MEM_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [2:0]       req0_write,
  input  logic [2:0]       req0_read,
  input  logic [31:0]      req0_addr,
  input  logic [31:0]      req0_wdata,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  input  logic [2:0]       req1_write,
  input  logic [2:0]       req1_read,
  input  logic [31:0]      req1_addr,
  input  logic [31:0]      req1_wdata,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             req_ready,
  output logic [2:0]       mem_write_o,
  output logic [2:0]       mem_read_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_wdata_o,
  input  logic [31:0]      mem_rdata_i,
  output logic             resp_valid,
  output logic [TAG_W-1:0] resp_tag,
  output logic [31:0]      resp_data
);

  localparam int CW = $clog2(DEPTH) + 1;
  // Room for two means count <= DEPTH-2; judged on registered count only so
  // a same-cycle pop never grants extra credit.
  localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);

  logic [CW-1:0] count;
  logic          take0;
  logic          take1;
  logic          slot_a_en;
  logic          slot_b_en;
  mem_req_t      lane0_req;
  mem_req_t      lane1_req;
  mem_req_t      slot_a;
  mem_req_t      head;
  logic          issue;

  assign req_ready = (count <= READY_MAX);

  assign take0 = req_ready && req0_valid && has_op(req0_write, req0_read);
  assign take1 = req_ready && req1_valid && has_op(req1_write, req1_read);

  assign lane0_req = make_req(req0_write, req0_read, req0_addr, req0_wdata, req0_tag);
  assign lane1_req = make_req(req1_write, req1_read, req1_addr, req1_wdata, req1_tag);

  // Lane 0 always goes first; a lone lane 1 takes the first slot.
  assign slot_a_en = take0 || take1;
  assign slot_b_en = take0 && take1;
  assign slot_a    = take0 ? lane0_req : lane1_req;

  mem_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr0_en   (slot_a_en),
    .wr0_data (slot_a),
    .wr1_en   (slot_b_en),
    .wr1_data (lane1_req),
    .rd_en    (issue),
    .rd_data  (head),
    .count    (count)
  );

  // Never idle while work is queued: the head issues and pops every cycle.
  assign issue = (count != '0);

  // Drive memory port 0 from the head entry, quiet when the queue is empty.
  always_comb begin
    mem_write_o = ST_NONE;
    mem_read_o  = LD_NONE;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (issue) begin
      mem_write_o = head.wr;
      mem_read_o  = head.rd;
      mem_addr_o  = head.addr;
      mem_wdata_o = head.wdata;
    end
  end

  // Capture load data at the end of its issue cycle; tag/data hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_tag   <= '0;
      resp_data  <= '0;
    end else begin
      resp_valid <= issue && (head.rd != LD_NONE);
      if (issue && (head.rd != LD_NONE)) begin
        resp_tag  <= head.tag;
        resp_data <= mem_rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter with a small byte-addressed memory model.
module tb_mem_req_arbiter;
  import mem_pkg::*;

  logic        clk;
  logic        rst;
  logic        req0_valid;
  logic [2:0]  req0_write;
  logic [2:0]  req0_read;
  logic [31:0] req0_addr;
  logic [31:0] req0_wdata;
  logic [4:0]  req0_tag;
  logic        req1_valid;
  logic [2:0]  req1_write;
  logic [2:0]  req1_read;
  logic [31:0] req1_addr;
  logic [31:0] req1_wdata;
  logic [4:0]  req1_tag;
  logic        req_ready;
  logic [2:0]  mem_write_o;
  logic [2:0]  mem_read_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        resp_valid;
  logic [4:0]  resp_tag;
  logic [31:0] resp_data;

  int checks;
  int errors;

  logic [31:0] dmem [16];

  mem_req_arbiter #(.DEPTH(4), .TAG_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_write  (req0_write),
    .req0_read   (req0_read),
    .req0_addr   (req0_addr),
    .req0_wdata  (req0_wdata),
    .req0_tag    (req0_tag),
    .req1_valid  (req1_valid),
    .req1_write  (req1_write),
    .req1_read   (req1_read),
    .req1_addr   (req1_addr),
    .req1_wdata  (req1_wdata),
    .req1_tag    (req1_tag),
    .req_ready   (req_ready),
    .mem_write_o (mem_write_o),
    .mem_read_o  (mem_read_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .resp_valid  (resp_valid),
    .resp_tag    (resp_tag),
    .resp_data   (resp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory load path: combinational, extension done by the memory.
  function automatic logic [31:0] ld_ext(input logic [2:0] op, input logic [1:0] off,
                                         input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = w[{off[1], 4'b0000} +: 16];
    case (op)
      LD_LBU:  return {24'h0, b};
      LD_LHU:  return {16'h0, h};
      LD_LB:   return {{24{b[7]}}, b};
      LD_LH:   return {{16{h[15]}}, h};
      LD_LW:   return w;
      default: return 32'h0;
    endcase
  endfunction

  assign mem_rdata_i = ld_ext(mem_read_o, mem_addr_o[1:0], dmem[mem_addr_o[5:2]]);

  // Data memory store path: write lands at the edge ending the issue cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) dmem[i] <= 32'h0;
    end else begin
      case (mem_write_o)
        ST_SB: dmem[mem_addr_o[5:2]][{mem_addr_o[1:0], 3'b000} +: 8] <= mem_wdata_o[7:0];
        ST_SH: dmem[mem_addr_o[5:2]][{mem_addr_o[1], 4'b0000} +: 16] <= mem_wdata_o[15:0];
        ST_SW: dmem[mem_addr_o[5:2]] <= mem_wdata_o;
        default: ;
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drv0(input logic v, input logic [2:0] w, input logic [2:0] r,
                      input logic [31:0] a, input logic [31:0] d, input logic [4:0] t);
    req0_valid = v; req0_write = w; req0_read = r;
    req0_addr = a; req0_wdata = d; req0_tag = t;
  endtask

  task automatic drv1(input logic v, input logic [2:0] w, input logic [2:0] r,
                      input logic [31:0] a, input logic [31:0] d, input logic [4:0] t);
    req1_valid = v; req1_write = w; req1_read = r;
    req1_addr = a; req1_wdata = d; req1_tag = t;
  endtask

  task automatic idle();
    drv0(1'b0, ST_NONE, LD_NONE, 32'h0, 32'h0, 5'd0);
    drv1(1'b0, ST_NONE, LD_NONE, 32'h0, 32'h0, 5'd0);
  endtask

  logic exp_ready [10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    int p;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_resp_tag", 32'(resp_tag), 32'h0);
    chk("rst_resp_data", resp_data, 32'h0);
    chk("rst_mem_write", 32'(mem_write_o), 32'h0);
    chk("rst_mem_read", 32'(mem_read_o), 32'h0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    rst = 1'b0;

    // Idle for 10 cycles
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("idle_ready_%0d", i), 32'(req_ready), 32'h1);
      chk($sformatf("idle_write_%0d", i), 32'(mem_write_o), 32'h0);
      chk($sformatf("idle_read_%0d", i), 32'(mem_read_o), 32'h0);
      chk($sformatf("idle_addr_%0d", i), mem_addr_o, 32'h0);
      chk($sformatf("idle_wdata_%0d", i), mem_wdata_o, 32'h0);
      chk($sformatf("idle_resp_%0d", i), 32'(resp_valid), 32'h0);
      step();
    end

    // SW then LW to the same address in one cycle
    drv0(1'b1, ST_SW, LD_NONE, 32'h8000_0010, 32'hDEAD_BEEF, 5'd0);
    drv1(1'b1, ST_NONE, LD_LW, 32'h8000_0010, 32'h0, 5'd7);
    chk("t2_ready", 32'(req_ready), 32'h1);
    step();
    idle();
    chk("t2_st_write", 32'(mem_write_o), 32'(ST_SW));
    chk("t2_st_read", 32'(mem_read_o), 32'h0);
    chk("t2_st_addr", mem_addr_o, 32'h8000_0010);
    chk("t2_st_wdata", mem_wdata_o, 32'hDEAD_BEEF);
    step();
    chk("t2_ld_read", 32'(mem_read_o), 32'(LD_LW));
    chk("t2_ld_write", 32'(mem_write_o), 32'h0);
    chk("t2_ld_addr", mem_addr_o, 32'h8000_0010);
    chk("t2_ld_noresp", 32'(resp_valid), 32'h0);
    step();
    chk("t2_resp_valid", 32'(resp_valid), 32'h1);
    chk("t2_resp_tag", 32'(resp_tag), 32'd7);
    chk("t2_resp_data", resp_data, 32'hDEAD_BEEF);
    chk("t2_empty_read", 32'(mem_read_o), 32'h0);
    step();
    chk("t2_resp_drop", 32'(resp_valid), 32'h0);
    chk("t2_tag_hold", 32'(resp_tag), 32'd7);
    chk("t2_data_hold", resp_data, 32'hDEAD_BEEF);

    // Lane 0 valid without an op, lane 1 LB
    drv0(1'b1, ST_NONE, LD_NONE, 32'h1234_5678, 32'hFFFF_FFFF, 5'd1);
    drv1(1'b1, ST_NONE, LD_LB, 32'h8000_0010, 32'h0, 5'd3);
    step();
    idle();
    chk("t3_lb_read", 32'(mem_read_o), 32'(LD_LB));
    chk("t3_lb_write", 32'(mem_write_o), 32'h0);
    chk("t3_lb_addr", mem_addr_o, 32'h8000_0010);
    step();
    chk("t3_single_entry", 32'(mem_read_o), 32'h0);
    chk("t3_resp_valid", 32'(resp_valid), 32'h1);
    chk("t3_resp_tag", 32'(resp_tag), 32'd3);
    chk("t3_resp_data", resp_data, 32'hFFFF_FFEF);
    step();

    // Two stores per cycle for 6 cycles, upstream holds while not ready
    p = 0;
    for (int c = 0; c < 10; c++) begin
      if (c < 6) begin
        drv0(1'b1, ST_SW, LD_NONE, 32'h8000_0040 + 32'(8 * p), 32'hA000_0000 + 32'(2 * p), 5'd0);
        drv1(1'b1, ST_SW, LD_NONE, 32'h8000_0044 + 32'(8 * p), 32'hA000_0001 + 32'(2 * p), 5'd0);
      end else begin
        idle();
      end
      chk($sformatf("t4_ready_c%0d", c), 32'(req_ready), 32'(exp_ready[c]));
      if (c >= 1 && c <= 8) begin
        chk($sformatf("t4_write_c%0d", c), 32'(mem_write_o), 32'(ST_SW));
        chk($sformatf("t4_wdata_c%0d", c), mem_wdata_o, 32'hA000_0000 + 32'(c - 1));
        chk($sformatf("t4_addr_c%0d", c), mem_addr_o, 32'h8000_0040 + 32'(4 * (c - 1)));
      end else begin
        chk($sformatf("t4_nowrite_c%0d", c), 32'(mem_write_o), 32'h0);
      end
      if (c < 6 && req_ready) p++;
      step();
    end
    idle();

    // Byte store merging and load extension
    drv0(1'b1, ST_SW, LD_NONE, 32'h8000_0020, 32'h1122_3344, 5'd0);
    drv1(1'b1, ST_SB, LD_NONE, 32'h8000_0020, 32'h0000_0055, 5'd0);
    chk("t5_ready0", 32'(req_ready), 32'h1);
    step();
    drv0(1'b1, ST_NONE, LD_LBU, 32'h8000_0020, 32'h0, 5'd1);
    drv1(1'b1, ST_NONE, LD_LB, 32'h8000_0020, 32'h0, 5'd2);
    chk("t5_ready1", 32'(req_ready), 32'h1);
    chk("t5_sw_issue", 32'(mem_write_o), 32'(ST_SW));
    step();
    idle();
    chk("t5_sb_issue", 32'(mem_write_o), 32'(ST_SB));
    chk("t5_sb_wdata", mem_wdata_o, 32'h0000_0055);
    step();
    chk("t5_lbu_issue", 32'(mem_read_o), 32'(LD_LBU));
    step();
    chk("t5_lb_issue", 32'(mem_read_o), 32'(LD_LB));
    chk("t5_lbu_valid", 32'(resp_valid), 32'h1);
    chk("t5_lbu_tag", 32'(resp_tag), 32'd1);
    chk("t5_lbu_data", resp_data, 32'h0000_0055);
    step();
    chk("t5_lb_valid", 32'(resp_valid), 32'h1);
    chk("t5_lb_tag", 32'(resp_tag), 32'd2);
    chk("t5_lb_data", resp_data, 32'h0000_0055);
    chk("t5_drained", 32'(mem_read_o), 32'h0);
    drv0(1'b1, ST_SB, LD_NONE, 32'h8000_0020, 32'h0000_0080, 5'd0);
    drv1(1'b1, ST_NONE, LD_LB, 32'h8000_0020, 32'h0, 5'd4);
    chk("t5_ready2", 32'(req_ready), 32'h1);
    step();
    idle();
    chk("t5_sb80_issue", 32'(mem_write_o), 32'(ST_SB));
    chk("t5_sb80_wdata", mem_wdata_o, 32'h0000_0080);
    chk("t5_sb80_noresp", 32'(resp_valid), 32'h0);
    step();
    chk("t5_lb80_issue", 32'(mem_read_o), 32'(LD_LB));
    step();
    chk("t5_lb80_valid", 32'(resp_valid), 32'h1);
    chk("t5_lb80_tag", 32'(resp_tag), 32'd4);
    chk("t5_lb80_data", resp_data, 32'hFFFF_FF80);
    step();

    // Reset with three entries queued, one of them a store
    drv0(1'b1, ST_NONE, LD_LW, 32'h8000_0010, 32'h0, 5'd10);
    drv1(1'b1, ST_NONE, LD_LW, 32'h8000_0020, 32'h0, 5'd11);
    step();
    drv0(1'b1, ST_SW, LD_NONE, 32'h8000_0034, 32'h1234_5678, 5'd0);
    drv1(1'b1, ST_NONE, LD_LW, 32'h8000_0034, 32'h0, 5'd12);
    chk("t6_ready", 32'(req_ready), 32'h1);
    chk("t6_ld0_issue", 32'(mem_read_o), 32'(LD_LW));
    step();
    idle();
    chk("t6_full_ready", 32'(req_ready), 32'h0);
    chk("t6_pre_resp", 32'(resp_valid), 32'h1);
    chk("t6_pre_read", 32'(mem_read_o), 32'(LD_LW));
    rst = 1'b1;
    #1;
    chk("t6_rst_read", 32'(mem_read_o), 32'h0);
    chk("t6_rst_write", 32'(mem_write_o), 32'h0);
    chk("t6_rst_addr", mem_addr_o, 32'h0);
    chk("t6_rst_resp", 32'(resp_valid), 32'h0);
    chk("t6_rst_tag", 32'(resp_tag), 32'h0);
    chk("t6_rst_data", resp_data, 32'h0);
    chk("t6_rst_ready", 32'(req_ready), 32'h1);
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t6_post_write_%0d", i), 32'(mem_write_o), 32'h0);
      chk($sformatf("t6_post_read_%0d", i), 32'(mem_read_o), 32'h0);
      chk($sformatf("t6_post_resp_%0d", i), 32'(resp_valid), 32'h0);
      step();
    end
    drv0(1'b1, ST_NONE, LD_LW, 32'h8000_0034, 32'h0, 5'd9);
    step();
    idle();
    chk("t6_probe_issue", 32'(mem_read_o), 32'(LD_LW));
    step();
    chk("t6_probe_valid", 32'(resp_valid), 32'h1);
    chk("t6_probe_tag", 32'(resp_tag), 32'd9);
    chk("t6_probe_data", resp_data, 32'h0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
